seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for a bank of NUM_DIGITS common-anode/cathode 7-segment digits.
- Holds a double-buffered BCD word with one decimal point per digit, decodes one digit per scan slot, and drives a shared segment bus plus per-digit enables.
- Adds leading-zero suppression, an inter-digit ghosting guard and glitch-free updates aligned to slot boundaries.
- Sits between the numeric datapath and the board display pins.

---
 rtl/seg7_scan_driver.sv | 150 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for NUM_DIGITS seven-segment digits.
// A shadow register collects updates from the datapath. The shadow is copied into
// the display register only at a slot boundary, so a digit never changes while lit.
// One digit is decoded per scan slot. The digit enables stay off for BLANK_CYCLES
// at the start of each slot, which prevents ghosting between neighbouring digits.
module seg7_scan_driver #(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned REFRESH_DIV    = 1000,
   parameter int unsigned BLANK_CYCLES   = 2,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_en,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    upd_pending
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0]        SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]        IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W:0]          BLANK_END  = (CNT_W + 1)'(BLANK_CYCLES);
   localparam logic [4*NUM_DIGITS-1:0] BLANK_WORD = '1;

   logic [CNT_W-1:0]        slot_cnt;
   logic [IDX_W-1:0]        idx;
   logic                    tick;
   logic [4*NUM_DIGITS-1:0] shadow_bcd;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic [4*NUM_DIGITS-1:0] disp_bcd;
   logic [NUM_DIGITS-1:0]   disp_dp;

   logic [3:0]              cur_bcd;
   logic                    cur_dp;
   logic                    cur_supp;
   logic                    zero_above;
   logic [6:0]              seg_dec;
   logic [NUM_DIGITS-1:0]   an_nxt;

   logic [6:0]              seg_lit;
   logic                    dp_lit;
   logic [NUM_DIGITS-1:0]   an_on;

   assign tick = (slot_cnt == SLOT_LAST);

   // Slot timing: count cycles within a slot and advance the digit index on each tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt <= '0;
         idx      <= '0;
      end else if (tick) begin
         slot_cnt <= '0;
         idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
         slot_cnt <= slot_cnt + CNT_W'(1);
      end
   end

   // Update handshake: a load arriving on a tick goes straight to the display
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_bcd  <= BLANK_WORD;
         shadow_dp   <= '0;
         disp_bcd    <= BLANK_WORD;
         disp_dp     <= '0;
         upd_pending <= 1'b0;
      end else if (load && tick) begin
         disp_bcd    <= bcd_in;
         disp_dp     <= dp_in;
         upd_pending <= 1'b0;
      end else if (load) begin
         shadow_bcd  <= bcd_in;
         shadow_dp   <= dp_in;
         upd_pending <= 1'b1;
      end else if (tick && upd_pending) begin
         disp_bcd    <= shadow_bcd;
         disp_dp     <= shadow_dp;
         upd_pending <= 1'b0;
      end
   end

   // Current digit select with leading-zero detection, scanning from the most significant digit down
   always_comb begin
      cur_bcd    = '0;
      cur_dp     = 1'b0;
      cur_supp   = 1'b0;
      zero_above = 1'b1;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         zero_above = zero_above && (disp_bcd[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
         if (idx == IDX_W'(NUM_DIGITS - 1 - k)) begin
            cur_bcd  = disp_bcd[4*(NUM_DIGITS-1-k) +: 4];
            cur_dp   = disp_dp[NUM_DIGITS-1-k];
            cur_supp = lz_en && (k != NUM_DIGITS - 1) && zero_above;
         end
      end
   end

   // BCD to lit-level segment pattern {g,f,e,d,c,b,a}; codes above 9 are blank
   always_comb begin
      seg_dec = 7'h00;
      case (cur_bcd)
         4'd0:    seg_dec = 7'h3F;
         4'd1:    seg_dec = 7'h06;
         4'd2:    seg_dec = 7'h5B;
         4'd3:    seg_dec = 7'h4F;
         4'd4:    seg_dec = 7'h66;
         4'd5:    seg_dec = 7'h6D;
         4'd6:    seg_dec = 7'h7D;
         4'd7:    seg_dec = 7'h07;
         4'd8:    seg_dec = 7'h7F;
         4'd9:    seg_dec = 7'h6F;
         default: seg_dec = 7'h00;
      endcase
   end

   // Digit enable: one-hot on idx once the blanking window of the slot has passed
   always_comb begin
      an_nxt = '0;
      if ({1'b0, slot_cnt} >= BLANK_END) begin
         for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            an_nxt[k] = (idx == IDX_W'(k));
         end
      end
   end

   // Output registers hold the lit-level values; pin polarity is applied after them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_lit <= '0;
         dp_lit  <= 1'b0;
         an_on   <= '0;
      end else begin
         seg_lit <= cur_supp ? 7'h00 : seg_dec;
         dp_lit  <= cur_dp;
         an_on   <= an_nxt;
      end
   end

   assign seg = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
   assign dp  = SEG_ACTIVE_LOW ? ~dp_lit  : dp_lit;
   assign an  = AN_ACTIVE_LOW  ? ~an_on   : an_on;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: the bench runs directed and random stimulus against seg7_scan_driver.
// The reference model tracks the scan position as a cycle count since reset. It also keeps
// the digit contents in plain arrays and derives the expected pin values from those.
module tb_seg7_scan_driver;

   localparam int unsigned ND = 4;
   localparam int unsigned RD = 8;
   localparam int unsigned BC = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          load = 1'b0;
   logic [15:0]   bcd_in = '0;
   logic [3:0]    dp_in = '0;
   logic          lz_en = 1'b0;
   logic [6:0]    seg;
   logic          dp;
   logic [3:0]    an;
   logic          upd_pending;

   int unsigned   n_checks = 0;
   int unsigned   n_fails = 0;
   bit            chk_en = 1'b0;

   seg7_scan_driver #(
      .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC),
      .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
      .lz_en(lz_en), .seg(seg), .dp(dp), .an(an), .upd_pending(upd_pending)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   string segs [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                        "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

   function automatic logic [6:0] lit_of(input int unsigned d);
      logic [6:0] m = '0;
      string s = segs[d];
      for (int i = 0; i < s.len(); i++) m[int'(s[i]) - 97] = 1'b1;
      return m;
   endfunction

   int unsigned m_n;
   logic [3:0]  m_disp [ND];
   logic [3:0]  m_sh   [ND];
   logic        m_ddp  [ND];
   logic        m_sdp  [ND];
   bit          m_pend;
   logic [6:0]  exp_seg = 7'h7F;
   logic        exp_dp  = 1'b1;
   logic [3:0]  exp_an  = 4'hF;
   logic        exp_pend = 1'b0;
   int unsigned m_slot, m_id;
   bit          m_sup;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n = 0;
         for (int i = 0; i < ND; i++) begin
            m_disp[i] = 4'hF; m_sh[i] = 4'hF; m_ddp[i] = 1'b0; m_sdp[i] = 1'b0;
         end
         m_pend = 0;
         exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_pend = 1'b0;
      end else begin
         m_slot = m_n % RD;
         m_id   = (m_n / RD) % ND;
         m_sup  = lz_en && (m_id > 0);
         for (int j = int'(m_id); j < ND; j++) if (m_disp[j] != 0) m_sup = 0;
         exp_seg = (m_sup || m_disp[m_id] > 9) ? 7'h7F : ~lit_of(m_disp[m_id]);
         exp_dp  = ~m_ddp[m_id];
         exp_an  = 4'hF;
         if (m_slot >= BC) exp_an[m_id] = 1'b0;
         if (load) begin
            for (int i = 0; i < ND; i++) begin
               if (m_slot == RD - 1) begin
                  m_disp[i] = bcd_in[4*i +: 4]; m_ddp[i] = dp_in[i];
               end else begin
                  m_sh[i] = bcd_in[4*i +: 4]; m_sdp[i] = dp_in[i];
               end
            end
            m_pend = (m_slot != RD - 1);
         end else if (m_slot == RD - 1 && m_pend) begin
            for (int i = 0; i < ND; i++) begin
               m_disp[i] = m_sh[i]; m_ddp[i] = m_sdp[i];
            end
            m_pend = 0;
         end
         exp_pend = m_pend;
         m_n++;
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_seg", seg, exp_seg);
         check("model_dp", dp, exp_dp);
         check("model_an", an, exp_an);
         check("model_pend", upd_pending, exp_pend);
      end
   end

   // wait until the outputs show scan position (idx, slot); idx < 0 means any digit
   task automatic wait_out(input int want_idx, input int unsigned want_slot);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (m_n > 0 && ((m_n - 1) % RD) == want_slot &&
             (want_idx < 0 || ((m_n - 1) / RD) % ND == want_idx)) return;
      end
      check("wait_out_timeout", 0, 1);
   endtask

   // wait until the next clock edge will sample slot_cnt == want_slot
   task automatic wait_next(input int unsigned want_slot);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if ((m_n % RD) == want_slot) return;
      end
      check("wait_next_timeout", 0, 1);
   endtask

   task automatic settle();
      repeat (RD) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_an", an, 4'hF);
      check("reset_seg", seg, 7'h7F);
      check("reset_dp", dp, 1'b1);
      check("reset_pend", upd_pending, 1'b0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("idle_seg", seg, 7'h7F);

      // 1234: basic scan
      wait_next(0);
      load = 1'b1; bcd_in = 16'h1234; dp_in = 4'h0;
      @(negedge clk) load = 1'b0;
      check("pend_after_load", upd_pending, 1'b1);
      settle();
      wait_out(0, 1);
      check("blank_window_an", an, 4'hF);
      wait_out(0, 3);
      check("digit4_seg", seg, 7'b0011001);
      check("digit4_an", an, 4'b1110);
      wait_out(3, 4);
      check("digit1_seg", seg, 7'b1111001);
      check("digit1_an", an, 4'b0111);

      // 0050 with leading-zero suppression
      lz_en = 1'b1;
      wait_next(0);
      load = 1'b1; bcd_in = 16'h0050;
      @(negedge clk) load = 1'b0;
      settle();
      wait_out(3, 4);
      check("lz_d3_seg", seg, 7'h7F);
      check("lz_d3_an", an, 4'b0111);
      wait_out(1, 4);
      check("lz_d1_seg", seg, 7'b0010010);
      wait_out(0, 4);
      check("lz_d0_seg", seg, 7'b1000000);

      // 0000 with dp on digit 2
      wait_next(0);
      load = 1'b1; bcd_in = 16'h0000; dp_in = 4'b0100;
      @(negedge clk) load = 1'b0;
      settle();
      wait_out(2, 5);
      check("lz_d2_seg", seg, 7'h7F);
      check("lz_d2_dp", dp, 1'b0);
      wait_out(0, 5);
      check("zero_d0_seg", seg, 7'b1000000);
      check("zero_d0_dp", dp, 1'b1);
      dp_in = 4'h0;

      // last of several loads within one slot wins
      wait_next(1);
      load = 1'b1; bcd_in = 16'h1111;
      @(negedge clk) bcd_in = 16'h2222;
      @(negedge clk) bcd_in = 16'h3333;
      @(negedge clk) load = 1'b0;
      check("multi_pend", upd_pending, 1'b1);
      settle();
      wait_out(-1, 4);
      check("multi_seg", seg, 7'b0110000);

      // load coinciding with a tick is applied directly
      wait_next(RD - 1);
      load = 1'b1; bcd_in = 16'h9876;
      @(negedge clk) load = 1'b0;
      check("tick_load_pend", upd_pending, 1'b0);
      wait_out(0, 2);
      check("tick_load_seg", seg, 7'b0000010);

      // randomized traffic
      for (int k = 0; k < 800; k++) begin
         @(negedge clk);
         load = ($urandom_range(0, 9) == 0);
         for (int i = 0; i < ND; i++)
            bcd_in[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         dp_in = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
      end
      @(negedge clk) load = 1'b0;

      // reset mid-slot with an update pending
      wait_out(2, 3);
      load = 1'b1; bcd_in = 16'h5555;
      @(negedge clk) load = 1'b0;
      check("pre_reset_pend", upd_pending, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_an", an, 4'hF);
      check("midrst_seg", seg, 7'h7F);
      check("midrst_dp", dp, 1'b1);
      check("midrst_pend", upd_pending, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      wait_out(0, 2);
      check("restart_an", an, 4'b1110);
      check("restart_seg", seg, 7'h7F);
      wait_out(1, 2);
      check("restart_d1_an", an, 4'b1101);
      check("discard_seg", seg, 7'h7F);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
